// File: rtl/bnn_weight_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : bnn_weight_loader_if
// Function : valid/ready weight-byte stream feeding the BNN weight loader.
// Revision : 1.0 - initial release
// ============================================================================
interface bnn_weight_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface
`default_nettype wire

// File: rtl/bnn_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : bnn_weight_loader
// Function : buffers weight bytes and writes them to the 8-8-4 BNN core as
//            LO/HI nibble pairs. Define BNN_WLOAD_CHECKSUM_EN to accept and
//            verify a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_weight_loader #(
  parameter int NUM_NEURONS = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  bnn_weight_loader_if.slave        s_if,
  output logic [3:0]                w_nibble,
  output logic                      w_load_en,
  output logic [4:0]                neuron_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

`ifdef BNN_WLOAD_CHECKSUM_EN
  localparam int TOTAL = NUM_NEURONS + 1;
`else
  localparam int TOTAL = NUM_NEURONS;
`endif
  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam int            CW        = $clog2(TOTAL + 1);
  localparam logic [4:0]    LAST_IDX  = 5'(NUM_NEURONS - 1);
  localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);

`ifdef BNN_WLOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_DONE = 3'd4
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [4:0]    neuron_idx_q, neuron_idx_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef BNN_WLOAD_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    head;
  logic          busy_w;
  logic          accept_ok;
  logic          push;
  logic          restart;
  logic          load_en_w;
  logic [3:0]    nibble_w;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

`ifdef BNN_WLOAD_CHECKSUM_EN
  assign busy_w = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CHK);
`else
  assign busy_w = (state_q == S_LO) || (state_q == S_HI);
`endif

  always_comb begin
    state_d      = state_q;
    neuron_idx_d = neuron_idx_q;
    acc_cnt_d    = acc_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
`ifdef BNN_WLOAD_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    accept_ok    = 1'b0;
    push         = 1'b0;
    restart      = 1'b0;
    load_en_w    = 1'b0;
    nibble_w     = 4'h0;

    if (ena) begin
      accept_ok = busy_w && !fifo_full && (acc_cnt_q < TOTAL_CNT);
      push      = accept_ok && s_if.s_valid;
      if (push) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        acc_cnt_d = acc_cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE: restart = start;
`ifdef BNN_WLOAD_CHECKSUM_EN
        S_ERR:          restart = start;
`endif
        S_LO: begin
          if (!fifo_empty) begin
            load_en_w = 1'b1;
            nibble_w  = head[3:0];
            state_d   = S_HI;
          end
        end
        // The HI half never stalls: the core expects both nibbles back to back.
        S_HI: begin
          load_en_w = 1'b1;
          nibble_w  = head[7:4];
          rd_ptr_d  = rd_ptr_q + 1'b1;
`ifdef BNN_WLOAD_CHECKSUM_EN
          xor_d     = xor_q ^ head;
`endif
          if (neuron_idx_q == LAST_IDX) begin
`ifdef BNN_WLOAD_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            neuron_idx_d = neuron_idx_q + 5'd1;
            state_d      = S_LO;
          end
        end
`ifdef BNN_WLOAD_CHECKSUM_EN
        S_CHK: begin
          if (!fifo_empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = (head == xor_q) ? S_DONE : S_ERR;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase

      if (restart) begin
        state_d      = S_LO;
        neuron_idx_d = '0;
        acc_cnt_d    = '0;
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
`ifdef BNN_WLOAD_CHECKSUM_EN
        xor_d        = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      neuron_idx_q <= '0;
      acc_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
`ifdef BNN_WLOAD_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      neuron_idx_q <= neuron_idx_d;
      acc_cnt_q    <= acc_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
`ifdef BNN_WLOAD_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  // Storage needs no reset: occupancy is defined entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_if.s_data;
    end
  end

  assign s_if.s_ready = accept_ok;
  assign w_load_en    = load_en_w;
  assign w_nibble     = nibble_w;
  assign neuron_idx   = neuron_idx_q;
  assign busy         = busy_w;
  assign done         = (state_q == S_DONE);
`ifdef BNN_WLOAD_CHECKSUM_EN
  assign err          = (state_q == S_ERR);
`else
  assign err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_weight_loader.sv
`default_nettype none
// Bench for bnn_weight_loader: random byte streams checked against a model of
// the core's weight port (nibble pairs assembled into weights[load pointer]).
module tb_bnn_weight_loader;
  localparam int NUM = 12;
`ifdef BNN_WLOAD_CHECKSUM_EN
  localparam int TOTAL      = NUM + 1;
  localparam int DONE_DELAY = 2;
`else
  localparam int TOTAL      = NUM;
  localparam int DONE_DELAY = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [3:0] w_nibble;
  logic       w_load_en;
  logic [4:0] neuron_idx;
  logic       busy, done, err;

  bnn_weight_loader_if s_if ();

  bnn_weight_loader #(.NUM_NEURONS(NUM), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .s_if       (s_if.slave),
    .w_nibble   (w_nibble),
    .w_load_en  (w_load_en),
    .neuron_idx (neuron_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] stim_q[$];
  int         pos;

  // Core-side reference: weights indexed by the core's own load pointer.
  logic [7:0] core_w [32];
  logic [3:0] nib_q[$];
  int         core_ptr, cyc, first_le, last_le, done_cyc, lone_err, idx_err;
  bit         have_lo;
  logic [3:0] lo_nib;

  function automatic void clear_model();
    core_ptr = 0; have_lo = 1'b0; first_le = -1; last_le = -1; done_cyc = -1;
    lone_err = 0; idx_err = 0; nib_q.delete();
    for (int i = 0; i < 32; i++) core_w[i] = 8'hxx;
  endfunction

  initial begin
    cyc = 0;
    clear_model();
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      clear_model();
    end else if (start && ena) begin
      clear_model();
    end else begin
      if (ena) begin
        if (w_load_en) begin
          nib_q.push_back(w_nibble);
          if (first_le < 0) first_le = cyc;
          last_le = cyc;
          if (neuron_idx != 5'(core_ptr)) idx_err++;
          if (!have_lo) begin
            lo_nib  = w_nibble;
            have_lo = 1'b1;
          end else begin
            if (core_ptr < 32) core_w[core_ptr] = {w_nibble, lo_nib};
            core_ptr++;
            have_lo = 1'b0;
          end
        end else if (have_lo) begin
          lone_err++;
          have_lo = 1'b0;
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic cycle_drive(input bit allow, input bit ena_v, input bit start_v);
    @(posedge clk);
    #1;
    ena          = ena_v;
    start        = start_v;
    s_if.s_valid = allow && (pos < stim_q.size());
    s_if.s_data  = s_if.s_valid ? stim_q[pos] : 8'($urandom);
    @(negedge clk);
    if (s_if.s_valid && s_if.s_ready) pos++;
  endtask

  task automatic run_to_end(input int mode, input int limit, output bit timed_out);
    bit allow;
    timed_out = 1'b1;
    for (int n = 0; n < limit; n++) begin
      case (mode)
        0:       allow = 1'b1;
        1:       allow = ((n / 3) % 2) == 0;
        default: allow = ($urandom_range(0, 1) == 1);
      endcase
      cycle_drive(allow, 1'b1, 1'b0);
      if (done || err) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) cycle_drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic append_checksum();
`ifdef BNN_WLOAD_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NUM; i++) x = x ^ stim_q[i];
    stim_q.push_back(x);
`endif
  endtask

  task automatic fill_random();
    stim_q.delete();
    for (int i = 0; i < NUM; i++) stim_q.push_back(8'($urandom));
    append_checksum();
    pos = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (s_if.s_ready !== 1'b0) $display("FAIL reset_s_ready got %b exp 0", s_if.s_ready); else n_pass++;
    n_checks++; if (w_nibble !== 4'h0) $display("FAIL reset_w_nibble got %h exp 0", w_nibble); else n_pass++;
    n_checks++; if (w_load_en !== 1'b0) $display("FAIL reset_w_load_en got %b exp 0", w_load_en); else n_pass++;
    n_checks++; if (neuron_idx !== 5'd0) $display("FAIL reset_neuron_idx got %0d exp 0", neuron_idx); else n_pass++;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got %b exp 000", {busy, done, err}); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    stim_q.delete(); pos = 0;
    repeat (2) cycle_drive(1'b1, 1'b1, 1'b0);
    n_checks++; if ({busy, s_if.s_ready} !== 2'b00) $display("FAIL idle_no_accept got %b exp 00", {busy, s_if.s_ready}); else n_pass++;
  endtask

  task automatic test_sequential_load();
    bit to;
    int werr, nerr;
    logic [7:0] b;
    stim_q.delete();
    for (int i = 0; i < NUM; i++) stim_q.push_back(8'(i));
    append_checksum();
    pos = 0;
    cycle_drive(1'b1, 1'b1, 1'b1);
    run_to_end(0, 200, to);
    werr = 0; nerr = 0;
    for (int i = 0; i < NUM; i++) begin
      b = stim_q[i];
      if (core_w[i] !== b) werr++;
      if (nib_q.size() != 2 * NUM || nib_q[2*i] !== b[3:0] || nib_q[2*i+1] !== b[7:4]) nerr++;
    end
    n_checks++; if (to !== 1'b0) $display("FAIL seq_timeout got %b exp 0", to); else n_pass++;
    n_checks++; if ({done, err, busy} !== 3'b100) $display("FAIL seq_status got %b exp 100", {done, err, busy}); else n_pass++;
    n_checks++; if (pos !== TOTAL) $display("FAIL seq_handshakes got %0d exp %0d", pos, TOTAL); else n_pass++;
    n_checks++; if (werr !== 0) $display("FAIL seq_weights got %0d bad exp 0", werr); else n_pass++;
    n_checks++; if (nerr !== 0) $display("FAIL seq_nibbles got %0d bad (n=%0d) exp 0", nerr, nib_q.size()); else n_pass++;
    n_checks++; if (last_le - first_le + 1 !== 2 * NUM) $display("FAIL seq_span got %0d exp %0d", last_le - first_le + 1, 2 * NUM); else n_pass++;
    n_checks++; if (done_cyc - last_le !== DONE_DELAY) $display("FAIL seq_done_delay got %0d exp %0d", done_cyc - last_le, DONE_DELAY); else n_pass++;
    n_checks++; if (idx_err !== 0) $display("FAIL seq_idx_align got %0d exp 0", idx_err); else n_pass++;
    n_checks++; if (s_if.s_ready !== 1'b0) $display("FAIL seq_ready_after got %b exp 0", s_if.s_ready); else n_pass++;
  endtask

  task automatic test_gaps();
    bit to;
    int werr;
    for (int run = 0; run < 2; run++) begin
      fill_random();
      cycle_drive(1'b1, 1'b1, 1'b1);
      run_to_end(run + 1, 400, to);
      werr = 0;
      for (int i = 0; i < NUM; i++) if (core_w[i] !== stim_q[i]) werr++;
      n_checks++; if (to !== 1'b0) $display("FAIL gap_timeout run %0d got %b exp 0", run, to); else n_pass++;
      n_checks++; if (werr !== 0) $display("FAIL gap_weights run %0d got %0d bad exp 0", run, werr); else n_pass++;
      n_checks++; if (lone_err !== 0 || nib_q.size() !== 2 * NUM) $display("FAIL gap_pairs run %0d got lone=%0d n=%0d exp 0/%0d", run, lone_err, nib_q.size(), 2 * NUM); else n_pass++;
      n_checks++; if ({done, err, idx_err} !== {2'b10, 32'd0}) $display("FAIL gap_status run %0d got d=%b e=%b idx=%0d exp 1/0/0", run, done, err, idx_err); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    bit to;
    int werr;
    fill_random();
    while (stim_q.size() < 20) stim_q.push_back(8'($urandom));
    cycle_drive(1'b1, 1'b1, 1'b1);
    run_to_end(0, 200, to);
    repeat (5) cycle_drive(1'b1, 1'b1, 1'b0);
    werr = 0;
    for (int i = 0; i < NUM; i++) if (core_w[i] !== stim_q[i]) werr++;
    n_checks++; if (pos !== TOTAL) $display("FAIL ovf_handshakes got %0d exp %0d", pos, TOTAL); else n_pass++;
    n_checks++; if (s_if.s_ready !== 1'b0) $display("FAIL ovf_ready got %b exp 0", s_if.s_ready); else n_pass++;
    n_checks++; if ({to, done, werr} !== {2'b01, 32'd0}) $display("FAIL ovf_result got to=%b done=%b werr=%0d exp 0/1/0", to, done, werr); else n_pass++;
  endtask

  task automatic test_ena_freeze();
    bit to, found;
    int werr, ferr, pos_before;
    logic [7:0] b3;
    fill_random();
    b3 = stim_q[3];
    cycle_drive(1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      cycle_drive(1'b1, 1'b1, 1'b0);
      if (w_load_en && neuron_idx == 5'd3) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) $display("FAIL ena_find_lo got %b exp 1", found); else n_pass++;
    pos_before = pos; ferr = 0;
    repeat (5) begin
      cycle_drive(1'b1, 1'b0, 1'b0);
      if (w_load_en !== 1'b0 || s_if.s_ready !== 1'b0 || neuron_idx !== 5'd3 || busy !== 1'b1 || done !== 1'b0) ferr++;
    end
    n_checks++; if (ferr !== 0) $display("FAIL ena_frozen got %0d bad cycles exp 0", ferr); else n_pass++;
    n_checks++; if (pos !== pos_before) $display("FAIL ena_no_accept got %0d exp %0d", pos, pos_before); else n_pass++;
    cycle_drive(1'b1, 1'b1, 1'b0);
    n_checks++; if ({w_load_en, w_nibble} !== {1'b1, b3[7:4]}) $display("FAIL ena_resume_hi got %b/%h exp 1/%h", w_load_en, w_nibble, b3[7:4]); else n_pass++;
    run_to_end(0, 200, to);
    werr = 0;
    for (int i = 0; i < NUM; i++) if (core_w[i] !== stim_q[i]) werr++;
    n_checks++; if ({to, done, werr, lone_err} !== {2'b01, 64'd0}) $display("FAIL ena_result got to=%b done=%b werr=%0d lone=%0d exp 0/1/0/0", to, done, werr, lone_err); else n_pass++;
  endtask

  task automatic test_reset_midload();
    bit to, found;
    int werr;
    fill_random();
    cycle_drive(1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      cycle_drive(1'b1, 1'b1, 1'b0);
      if (neuron_idx == 5'd5) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rst_find_idx5 got %b exp 1", found); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({w_load_en, w_nibble, s_if.s_ready} !== 6'd0) $display("FAIL rst_port_zero got %b exp 0", {w_load_en, w_nibble, s_if.s_ready}); else n_pass++;
    n_checks++; if ({neuron_idx, busy, done, err} !== 8'd0) $display("FAIL rst_status_zero got %b exp 0", {neuron_idx, busy, done, err}); else n_pass++;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fill_random();
    cycle_drive(1'b1, 1'b1, 1'b0);
    n_checks++; if ({busy, s_if.s_ready, w_load_en} !== 3'b000) $display("FAIL rst_idle_after got %b exp 000", {busy, s_if.s_ready, w_load_en}); else n_pass++;
    cycle_drive(1'b1, 1'b1, 1'b1);
    run_to_end(2, 400, to);
    werr = 0;
    for (int i = 0; i < NUM; i++) if (core_w[i] !== stim_q[i]) werr++;
    n_checks++; if ({to, done, werr, idx_err} !== {2'b01, 64'd0}) $display("FAIL rst_reload got to=%b done=%b werr=%0d idx=%0d exp 0/1/0/0", to, done, werr, idx_err); else n_pass++;
    n_checks++; if (core_ptr !== NUM) $display("FAIL rst_reload_ptr got %0d exp %0d", core_ptr, NUM); else n_pass++;
  endtask

`ifdef BNN_WLOAD_CHECKSUM_EN
  task automatic test_checksum();
    bit to;
    int werr;
    logic [7:0] last;
    logic exp_done;
    for (int k = 0; k < 3; k++) begin
      stim_q.delete();
      if (k < 2) begin
        for (int i = 0; i < NUM; i++) stim_q.push_back(8'h11);
        last = (k == 0) ? 8'h00 : 8'h01;
        stim_q.push_back(last);
      end else begin
        for (int i = 0; i < NUM; i++) stim_q.push_back(8'($urandom));
        append_checksum();
        last = stim_q[NUM] ^ (8'h01 << $urandom_range(0, 7));
        stim_q[NUM] = last;
      end
      pos = 0;
      exp_done = (k == 0);
      cycle_drive(1'b1, 1'b1, 1'b1);
      run_to_end(2, 400, to);
      werr = 0;
      for (int i = 0; i < NUM; i++) if (core_w[i] !== stim_q[i]) werr++;
      n_checks++; if (to !== 1'b0) $display("FAIL csum_timeout case %0d got %b exp 0", k, to); else n_pass++;
      n_checks++; if ({done, err, busy} !== {exp_done, ~exp_done, 1'b0}) $display("FAIL csum_status case %0d got %b exp %b", k, {done, err, busy}, {exp_done, ~exp_done, 1'b0}); else n_pass++;
      n_checks++; if ({werr, pos} !== {32'd0, 32'(TOTAL)}) $display("FAIL csum_data case %0d got werr=%0d pos=%0d exp 0/%0d", k, werr, pos, TOTAL); else n_pass++;
    end
  endtask
`endif

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = 8'h00;
    pos = 0;
    test_reset();
    test_sequential_load();
    test_gaps();
    test_overflow();
    test_ena_freeze();
    test_reset_midload();
`ifdef BNN_WLOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired: %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
